packet_serializer: RTL
======================

// Module: packet_serializer
// PURPOSE
//  Parametrised framer: wraps NUM_CH consecutive input words as HEADER, NUM_CH data beats, FOOTER.
//  FOOTER is a fixed word or a running XOR checksum of the data beats.
//  Valid/ready handshake on both sides; the downstream sink may stall.
//  Sits between channel sources and the serial link/readout stage.
// PARAMETERS
//  DATA_W      8      word width of din/dout
//  NUM_CH      4      data beats per packet (>=1)
//  HEADER      'hAA   header word, DATA_W bits
//  FOOTER      'hFF   footer word when FOOTER_MODE=0, DATA_W bits
//  FOOTER_MODE 0      0: fixed FOOTER; 1: XOR of all NUM_CH data words
//  CNT_W       16     width of pkt_count
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  din        in   DATA_W  channel data word
//  din_valid  in   1       din holds a word
//  din_ready  out  1       word consumed this cycle when din_valid & din_ready
//  dout       out  DATA_W  framed output word
//  dout_valid out  1       dout holds a beat
//  dout_ready in   1       sink accepts the beat this cycle
//  dout_sop   out  1       beat is HEADER
//  dout_eop   out  1       beat is FOOTER
//  busy       out  1       state != IDLE
//  pkt_count  out  CNT_W   packets whose footer was loaded; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; dout=0; dout_valid=0; dout_sop=0; dout_eop=0.
//   Also cnt=0, chk=0, pkt_count=0.
//  Outputs are all registered. Define adv = !dout_valid | dout_ready.
//  The output register loads only when adv=1. While adv=0, all outputs hold and the FSM holds.
//  din_ready = (state==DATA) & adv. It is a combinational function of state and dout_valid/dout_ready.
//  FSM:
//   IDLE: din_valid & adv -> load HEADER, sop=1, eop=0, valid=1; cnt<=0; chk<=0; ->DATA.
//    din is not consumed in IDLE.
//    adv & !din_valid -> valid<=0.
//   DATA: din_valid & din_ready -> load din, sop=eop=0, valid=1; chk<=chk^din.
//    If cnt==NUM_CH-1 -> FTR; otherwise cnt<=cnt+1.
//    adv & !din_valid -> valid<=0 (bubble); state, cnt and chk hold.
//   FTR: adv -> load FOOTER (MODE 0) or chk (MODE 1), eop=1, valid=1; pkt_count+=1; ->IDLE.
//  cnt width: $clog2(NUM_CH), minimum 1.
//  NUM_CH=1: DATA goes to FTR after a single beat.
//  Latency: HEADER is on dout one cycle after din_valid is first seen in IDLE with adv=1.
//  Back-to-back packets: the next HEADER loads in the cycle the FOOTER is accepted. No idle gap.
//  Full throughput: one beat per clock while din_valid=1 and dout_ready=1.
//   A packet therefore occupies NUM_CH+2 beats.
//  A din_valid drop mid-packet only inserts bubbles; the packet is never truncated.
//  Stall on a sop/eop beat: the beat and its flags hold unchanged until accepted.
//  Reset asserted mid-packet: the partial packet is discarded and outputs clear immediately.
//   After release, the next packet starts with a fresh HEADER.
//  pkt_count at 2^CNT_W-1 wraps to 0 on the next footer.
// TESTING
//  T1 reset: rst_n=0 mid-packet.
//   -> dout_valid=0, sop=eop=0, busy=0, pkt_count=0 without waiting for a clock edge.
//  T2 basic: defaults, dout_ready=1, din=11,22,33,44 continuous.
//   -> dout AA,11,22,33,44,FF on consecutive cycles; sop on AA; eop on FF; pkt_count=1.
//  T3 checksum: FOOTER_MODE=1, din=01,02,04,08.
//   -> footer=0F with eop=1; a second packet 0F,0F,00,00 -> footer=00.
//  T4 backpressure: dout_ready=0 for 3 cycles on the 2nd data beat.
//   -> dout holds 22, din_ready=0, no word lost or duplicated.
//  T5 source gaps: din_valid toggles 1/0.
//   -> bubbles (dout_valid=0) appear between beats; the order is still AA,d0..d3,FF.
//  T6 back-to-back and wrap: 2 packets continuous, then CNT_W=2 with 5 packets.
//   -> no gap between FF and AA; pkt_count runs 1,2,3,0,1.

Source files
------------

// File: rtl/packet_serializer.sv
// packet_serializer: frames NUM_CH consecutive input words as HEADER, NUM_CH data beats, FOOTER
// Ports: clk, rst_n (async active-low); din/din_valid/din_ready upstream handshake;
//        dout/dout_valid/dout_ready downstream handshake with dout_sop (HEADER beat) and
//        dout_eop (FOOTER beat); busy (not idle); pkt_count (footers loaded, wrapping).
module packet_serializer #(
   parameter int                DATA_W      = 8,
   parameter int                NUM_CH      = 4,
   parameter logic [DATA_W-1:0] HEADER      = 'hAA,
   parameter logic [DATA_W-1:0] FOOTER      = 'hFF,
   parameter int                FOOTER_MODE = 0,
   parameter int                CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              dout_sop,
   output logic              dout_eop,
   output logic              busy,
   output logic [CNT_W-1:0]  pkt_count
);
   localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   typedef enum logic [1:0] {IDLE, DATA, FTR} state_t;
   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [DATA_W-1:0] chk, chk_nxt, dout_nxt;
   logic              valid_nxt, sop_nxt, eop_nxt, adv;
   logic [CNT_W-1:0]  pkt_nxt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         chk        <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_sop   <= 1'b0;
         dout_eop   <= 1'b0;
         pkt_count  <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         chk        <= chk_nxt;
         dout       <= dout_nxt;
         dout_valid <= valid_nxt;
         dout_sop   <= sop_nxt;
         dout_eop   <= eop_nxt;
         pkt_count  <= pkt_nxt;
      end
   end
   // The output register is the only buffer: it may load whenever it is empty or being drained.
   always_comb begin
      adv       = !dout_valid | dout_ready;
      din_ready = (state == DATA) & adv;
      busy      = state != IDLE;
      state_nxt = state;
      cnt_nxt   = cnt;
      chk_nxt   = chk;
      dout_nxt  = dout;
      valid_nxt = dout_valid;
      sop_nxt   = dout_sop;
      eop_nxt   = dout_eop;
      pkt_nxt   = pkt_count;
      if (adv) begin
         case (state)
            IDLE: begin
               valid_nxt = din_valid;
               sop_nxt   = din_valid;
               eop_nxt   = 1'b0;
               if (din_valid) begin
                  dout_nxt  = HEADER;
                  cnt_nxt   = '0;
                  chk_nxt   = '0;
                  state_nxt = DATA;
               end
            end
            DATA: begin
               valid_nxt = din_valid;
               sop_nxt   = 1'b0;
               eop_nxt   = 1'b0;
               if (din_valid) begin
                  dout_nxt  = din;
                  chk_nxt   = chk ^ din;
                  cnt_nxt   = cnt + CW'(1);
                  state_nxt = cnt == CW'(NUM_CH - 1) ? FTR : DATA;
               end
            end
            default: begin
               dout_nxt  = FOOTER_MODE != 0 ? chk : FOOTER;
               valid_nxt = 1'b1;
               sop_nxt   = 1'b0;
               eop_nxt   = 1'b1;
               pkt_nxt   = pkt_count + CNT_W'(1);
               state_nxt = IDLE;
            end
         endcase
      end
   end
endmodule
